// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  typedef enum logic {RUN, MD_BUSY} state_t;
  localparam logic [1:0] RD_BRANCH = 2'd0;
  localparam logic [1:0] RD_FALLTHRU = 2'd1;
  localparam logic [1:0] RD_JUMP = 2'd2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect control for the 5-stage pipeline
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W = pipe_ctrl_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs_ID,
  input  logic [REG_W-1:0] Rt_ID,
  input  logic             UseRs_ID,
  input  logic             UseRt_ID,
  input  logic             MdStart_ID,
  input  logic             MdUse_ID,
  input  logic             MemToReg_Ex,
  input  logic             RegWr_Ex,
  input  logic [REG_W-1:0] WrReg_Ex,
  input  logic             Branch_Ex,
  input  logic             BranchPredict_Ex,
  input  logic             BranchTaken_Ex,
  input  logic             Jump_Ex,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             redirect_valid,
  output logic [1:0]       redirect_sel,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t r_state, w_next;
  logic [5:0] r_md_cnt;
  logic r_md_done;
  logic w_mispredict, w_redirect, w_lu, w_md_hz, w_stall, w_issue;
  assign w_mispredict = Branch_Ex & (BranchTaken_Ex != BranchPredict_Ex);
  assign w_redirect = !rst & (w_mispredict | Jump_Ex);
  assign w_lu = MemToReg_Ex & RegWr_Ex & (WrReg_Ex != '0) &
                ((UseRs_ID & (Rs_ID == WrReg_Ex)) | (UseRt_ID & (Rt_ID == WrReg_Ex)));
  assign md_busy = (r_state == MD_BUSY);
  assign md_done = r_md_done;
  assign w_md_hz = md_busy & (MdStart_ID | MdUse_ID);
  assign w_stall = !rst & !w_redirect & (w_lu | w_md_hz);
  assign w_issue = !rst & (r_state == RUN) & MdStart_ID & !w_redirect & !w_lu;
  assign pc_stall = w_stall;
  assign if_id_stall = w_stall;
  assign if_id_flush = w_redirect;
  assign id_ex_flush = w_redirect | w_stall;
  assign redirect_valid = w_redirect;
  assign redirect_sel = !w_redirect ? RD_BRANCH :
                        Jump_Ex ? RD_JUMP :
                        BranchTaken_Ex ? RD_BRANCH : RD_FALLTHRU;
  // if-based transitions so an unknown issue condition leaves the FSM in place
  always_comb begin
    w_next = r_state;
    if (r_state == RUN) begin
      if (w_issue) w_next = MD_BUSY;
    end else if (r_md_cnt == 6'd1) w_next = RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_md_cnt <= '0;
      r_md_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_md_done <= md_busy && (r_md_cnt == 6'd1);
      if (w_issue) r_md_cnt <= 6'(MD_LATENCY - 1);
      else if (md_busy) r_md_cnt <= r_md_cnt - 6'd1;
    end
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(w_stall), .cnt(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(w_redirect), .cnt(flush_cnt));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of hazard, redirect, MDU and counter behaviour
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs_ID, Rt_ID, WrReg_Ex;
  logic UseRs_ID, UseRt_ID, MdStart_ID, MdUse_ID, MemToReg_Ex, RegWr_Ex;
  logic Branch_Ex, BranchPredict_Ex, BranchTaken_Ex, Jump_Ex;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_flush, redirect_valid, md_busy, md_done;
  logic [1:0] redirect_sel;
  logic [3:0] stall_cnt, flush_cnt;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.MD_LATENCY(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID),
    .MdStart_ID(MdStart_ID), .MdUse_ID(MdUse_ID), .MemToReg_Ex(MemToReg_Ex), .RegWr_Ex(RegWr_Ex),
    .WrReg_Ex(WrReg_Ex), .Branch_Ex(Branch_Ex), .BranchPredict_Ex(BranchPredict_Ex),
    .BranchTaken_Ex(BranchTaken_Ex), .Jump_Ex(Jump_Ex), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel), .md_busy(md_busy),
    .md_done(md_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    {Rs_ID, Rt_ID, WrReg_Ex} = '0;
    {UseRs_ID, UseRt_ID, MdStart_ID, MdUse_ID, MemToReg_Ex, RegWr_Ex} = '0;
    {Branch_Ex, BranchPredict_Ex, BranchTaken_Ex, Jump_Ex} = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_use(input logic [4:0] r);
    MemToReg_Ex = 1'b1;
    RegWr_Ex = 1'b1;
    WrReg_Ex = r;
    Rs_ID = r;
    UseRs_ID = 1'b1;
  endtask
  initial begin
    clr();
    rst = 1'b1;
    Jump_Ex = 1'b1;
    load_use(5'd8);
    #2;
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_pc_stall", pc_stall, 0);
    chk("rst_id_ex_flush", id_ex_flush, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    step();
    clr();
    rst = 1'b0;
    step();
    load_use(5'd8);
    #1;
    chk("lu_pc_stall", pc_stall, 1);
    chk("lu_if_id_stall", if_id_stall, 1);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    chk("lu_if_id_flush", if_id_flush, 0);
    step();
    clr();
    #1;
    chk("lu_one_cycle", pc_stall, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    load_use(5'd0);
    #1;
    chk("lu_zero_reg", pc_stall, 0);
    step();
    chk("lu_zero_cnt", stall_cnt, 1);
    clr();
    MemToReg_Ex = 1'b1; RegWr_Ex = 1'b1; WrReg_Ex = 5'd5; Rt_ID = 5'd5; UseRt_ID = 1'b1;
    #1;
    chk("lu_rt_stall", pc_stall, 1);
    step();
    clr();
    chk("lu_rt_cnt", stall_cnt, 2);
    Branch_Ex = 1'b1; BranchPredict_Ex = 1'b0; BranchTaken_Ex = 1'b1;
    #1;
    chk("mp_taken_valid", redirect_valid, 1);
    chk("mp_taken_sel", redirect_sel, 0);
    chk("mp_taken_ifid_flush", if_id_flush, 1);
    chk("mp_taken_idex_flush", id_ex_flush, 1);
    chk("mp_taken_pc_stall", pc_stall, 0);
    step();
    chk("mp_flush_cnt1", flush_cnt, 1);
    BranchPredict_Ex = 1'b1; BranchTaken_Ex = 1'b0;
    #1;
    chk("mp_nt_sel", redirect_sel, 1);
    chk("mp_nt_valid", redirect_valid, 1);
    step();
    chk("mp_flush_cnt2", flush_cnt, 2);
    clr();
    Jump_Ex = 1'b1;
    #1;
    chk("jump_sel", redirect_sel, 2);
    step();
    clr();
    chk("jump_flush_cnt", flush_cnt, 3);
    Branch_Ex = 1'b1; BranchPredict_Ex = 1'b1; BranchTaken_Ex = 1'b1;
    #1;
    chk("correct_pred", redirect_valid, 0);
    step();
    clr();
    load_use(5'd9);
    Branch_Ex = 1'b1; BranchTaken_Ex = 1'b1;
    #1;
    chk("both_redirect", redirect_valid, 1);
    chk("both_pc_stall", pc_stall, 0);
    chk("both_if_id_stall", if_id_stall, 0);
    step();
    clr();
    chk("both_stall_cnt", stall_cnt, 2);
    chk("both_flush_cnt", flush_cnt, 4);
    MdStart_ID = 1'b1;
    #1;
    chk("md_issue_busy", md_busy, 0);
    chk("md_issue_stall", pc_stall, 0);
    step();
    clr();
    MdUse_ID = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk($sformatf("md_busy_%0d", i), md_busy, 1);
      chk($sformatf("md_stall_%0d", i), pc_stall, 1);
      chk($sformatf("md_nodone_%0d", i), md_done, 0);
      step();
    end
    chk("md_busy_fall", md_busy, 0);
    chk("md_done_pulse", md_done, 1);
    chk("mfhi_proceeds", pc_stall, 0);
    chk("md_stall_cnt", stall_cnt, 9);
    step();
    chk("md_done_once", md_done, 0);
    clr();
    MdStart_ID = 1'b1;
    step();
    clr();
    Jump_Ex = 1'b1;
    step();
    clr();
    chk("md_survives_redirect", md_busy, 1);
    step();
    step();
    MdUse_ID = 1'b1;
    Jump_Ex = 1'b1;
    #1;
    chk("mid_busy_pre_rst", md_busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_md_busy", md_busy, 0);
    chk("arst_redirect", redirect_valid, 0);
    chk("arst_stall", pc_stall, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_flush_cnt", flush_cnt, 0);
    step();
    clr();
    rst = 1'b0;
    step();
    chk("post_rst_busy", md_busy, 0);
    load_use(5'd3);
    for (int i = 0; i < 15; i++) step();
    chk("sat_reach", stall_cnt, 15);
    for (int i = 0; i < 6; i++) step();
    chk("sat_hold", stall_cnt, 15);
    chk("sat_stall_still", pc_stall, 1);
    clr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
